// File: rtl/rgmii_defs.sv
// Shared RGMII receive definitions: field widths, in-band speed codes,
// nibble-assembler state encoding and the in-band status layout.
package rgmii_defs;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SPEED_2M5  = 2'b00;
  localparam logic [1:0] SPEED_25M  = 2'b01;
  localparam logic [1:0] SPEED_125M = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } asm_state_e;

  // Bit order matches the in-band nibble {duplex, speed[1:0], link}.
  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } inband_status_t;

endpackage

// File: rtl/rgmii_status_filter.sv
// Debounces the RGMII in-band status nibble: a candidate commits only after
// STATUS_FILTER consecutive identical idle samples.
module rgmii_status_filter
  import rgmii_defs::*;
#(
  parameter int unsigned STATUS_FILTER = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sample_valid_i,
  input  logic [NIB_W-1:0] candidate_i,
  output inband_status_t   status_o,
  output logic             status_change_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STATUS_FILTER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NIB_W-1:0] prev_q, prev_d;
  inband_status_t   status_q, status_d;
  logic             change_q, change_d;

  // Run-length count of the candidate; frozen on non-sample cycles.
  always_comb begin
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    status_d = status_q;
    change_d = 1'b0;
    if (sample_valid_i) begin
      prev_d = candidate_i;
      if (candidate_i != prev_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_d == CNT_TGT) && (inband_status_t'(candidate_i) != status_q)) begin
        status_d = inband_status_t'(candidate_i);
        change_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      prev_q   <= '0;
      status_q <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      status_q <= status_d;
      change_q <= change_d;
    end
  end

  assign status_o        = status_q;
  assign status_change_o = change_q;

endmodule

// File: rtl/rgmii_rx_adapter.sv
// RGMII receive adapter: 1G pass-through or 10/100 nibble-to-byte assembly,
// plus filtered in-band link status.
module rgmii_rx_adapter
  import rgmii_defs::*;
#(
  parameter int unsigned STATUS_FILTER = 4,
  parameter int unsigned AUTO_SPEED    = 1
) (
  input  logic              rx_clk,
  input  logic              rx_reset,
  input  logic              speed_10_100,
  input  logic [BYTE_W-1:0] gmii_rxd_in,
  input  logic              gmii_rx_dv_in,
  input  logic              gmii_rx_er_in,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_data_en,
  output logic              rx_dv,
  output logic              rx_er,
  output logic              rx_odd_nibble,
  output logic              link_status,
  output logic [1:0]        clock_speed,
  output logic              duplex_status,
  output logic              status_change
);

  asm_state_e        state_q, state_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic              nib_er_q, nib_er_d;
  logic              mode_q, mode_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              er_q, er_d;
  logic              odd_q, odd_d;
  logic              dv_q;
  inband_status_t    status;
  logic              status_chg;
  logic              mode_cfg, dv_rise, mode_cur;

  // Mode is sampled on the rising edge of dv and held for the whole frame.
  assign mode_cfg = (AUTO_SPEED != 32'd0) ? (status.speed != SPEED_125M) : speed_10_100;
  assign dv_rise  = gmii_rx_dv_in & ~dv_q;
  assign mode_cur = dv_rise ? mode_cfg : mode_q;

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    nib_er_d = nib_er_q;
    mode_d   = mode_cur;
    data_d   = data_q;
    en_d     = 1'b0;
    er_d     = 1'b0;
    odd_d    = 1'b0;
    if (!mode_cur) begin
      state_d = ST_IDLE;
      data_d  = gmii_rxd_in;
      en_d    = gmii_rx_dv_in;
      er_d    = gmii_rx_er_in & gmii_rx_dv_in;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_EVEN: begin
          if (gmii_rx_dv_in) begin
            state_d  = ST_ODD;
            nib_d    = gmii_rxd_in[NIB_W-1:0];
            nib_er_d = gmii_rx_er_in;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ODD: begin
          if (gmii_rx_dv_in) begin
            state_d = ST_EVEN;
            data_d  = {gmii_rxd_in[NIB_W-1:0], nib_q};
            en_d    = 1'b1;
            er_d    = nib_er_q | gmii_rx_er_in;
          end else begin
            state_d = ST_IDLE;
            odd_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q  <= ST_IDLE;
      nib_q    <= '0;
      nib_er_q <= 1'b0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      er_q     <= 1'b0;
      odd_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      nib_q    <= nib_d;
      nib_er_q <= nib_er_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      en_q     <= en_d;
      er_q     <= er_d;
      odd_q    <= odd_d;
      dv_q     <= gmii_rx_dv_in;
    end
  end

  rgmii_status_filter #(
    .STATUS_FILTER(STATUS_FILTER)
  ) u_status_filter (
    .clk_i          (rx_clk),
    .rst_i          (rx_reset),
    .sample_valid_i (~gmii_rx_dv_in & ~gmii_rx_er_in),
    .candidate_i    (gmii_rxd_in[NIB_W-1:0]),
    .status_o       (status),
    .status_change_o(status_chg)
  );

  assign rx_data       = data_q;
  assign rx_data_en    = en_q;
  assign rx_dv         = dv_q;
  assign rx_er         = er_q;
  assign rx_odd_nibble = odd_q;
  assign link_status   = status.link;
  assign clock_speed   = status.speed;
  assign duplex_status = status.duplex;
  assign status_change = status_chg;

endmodule

// File: tb/tb_rgmii_rx_adapter.sv
// Testbench for rgmii_rx_adapter: directed scenarios plus random frames,
// checked against a frame-level reference model built from the stimulus.
module tb_rgmii_rx_adapter;

  localparam int FILT = 4;
  localparam int MAXN = 256;

  logic       rx_clk = 1'b0;
  logic       rx_reset, speed_10_100, gmii_rx_dv_in, gmii_rx_er_in;
  logic [7:0] gmii_rxd_in;
  logic [7:0] rx_data;
  logic       rx_data_en, rx_dv, rx_er, rx_odd_nibble;
  logic       link_status, duplex_status, status_change;
  logic [1:0] clock_speed;

  rgmii_rx_adapter #(.STATUS_FILTER(FILT), .AUTO_SPEED(0)) dut (
    .rx_clk(rx_clk), .rx_reset(rx_reset), .speed_10_100(speed_10_100),
    .gmii_rxd_in(gmii_rxd_in), .gmii_rx_dv_in(gmii_rx_dv_in), .gmii_rx_er_in(gmii_rx_er_in),
    .rx_data(rx_data), .rx_data_en(rx_data_en), .rx_dv(rx_dv), .rx_er(rx_er),
    .rx_odd_nibble(rx_odd_nibble), .link_status(link_status), .clock_speed(clock_speed),
    .duplex_status(duplex_status), .status_change(status_change)
  );

  always #5 rx_clk = ~rx_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stim;

  // stimulus, expected and observed per cycle (index k = after edge k)
  logic       s_rst[MAXN], s_dv[MAXN], s_er[MAXN], s_spd[MAXN];
  logic [7:0] s_rxd[MAXN];
  logic       e_en[MAXN], e_er[MAXN], e_dv[MAXN], e_odd[MAXN], e_chg[MAXN];
  logic [7:0] e_data[MAXN];
  logic [3:0] e_st[MAXN];
  logic       o_en[MAXN], o_er[MAXN], o_dv[MAXN], o_odd[MAXN], o_chg[MAXN];
  logic [7:0] o_data[MAXN];
  logic [3:0] o_st[MAXN];

  task automatic push(input logic rst, input logic dv, input logic er,
                      input logic [7:0] rxd, input logic spd);
    if (n_stim < MAXN) begin
      s_rst[n_stim] = rst; s_dv[n_stim] = dv; s_er[n_stim] = er;
      s_rxd[n_stim] = rxd; s_spd[n_stim] = spd;
      n_stim++;
    end
  endtask

  // Reference: split stimulus into frames, then apply byte/nibble rules per frame.
  task automatic build_model();
    int s, e, lo, hi, run;
    logic [3:0] committed, prevc, cand;
    for (int k = 0; k < n_stim; k++) begin
      e_en[k] = 0; e_er[k] = 0; e_odd[k] = 0; e_chg[k] = 0; e_data[k] = '0;
      e_dv[k] = s_dv[k] & ~s_rst[k];
    end
    s = 0;
    while (s < n_stim) begin
      if (s_dv[s] && !s_rst[s] && (s == 0 || !s_dv[s-1] || s_rst[s-1])) begin
        e = s;
        while (e + 1 < n_stim && s_dv[e+1] && !s_rst[e+1]) e++;
        if (!s_spd[s]) begin
          for (int k = s; k <= e; k++) begin
            e_en[k] = 1; e_data[k] = s_rxd[k]; e_er[k] = s_er[k];
          end
        end else begin
          for (int p = 0; s + 2*p + 1 <= e; p++) begin
            lo = s + 2*p; hi = lo + 1;
            e_en[hi] = 1;
            e_data[hi] = {s_rxd[hi][3:0], s_rxd[lo][3:0]};
            e_er[hi] = s_er[lo] | s_er[hi];
          end
          if (((e - s + 1) % 2) == 1 && e + 1 < n_stim && !s_rst[e+1]) e_odd[e+1] = 1;
        end
        s = e + 1;
      end else begin
        s++;
      end
    end
    committed = 0; prevc = 0; run = 0;
    for (int k = 0; k < n_stim; k++) begin
      if (s_rst[k]) begin
        committed = 0; prevc = 0; run = 0;
      end else if (!s_dv[k] && !s_er[k]) begin
        cand = s_rxd[k][3:0];
        run = (cand == prevc) ? run + 1 : 1;
        prevc = cand;
        if (run == FILT && cand != committed) begin
          committed = cand; e_chg[k] = 1;
        end
      end
      e_st[k] = committed;
    end
  endtask

  task automatic run_scn();
    build_model();
    for (int k = 0; k < n_stim; k++) begin
      rx_reset = s_rst[k]; gmii_rx_dv_in = s_dv[k]; gmii_rx_er_in = s_er[k];
      gmii_rxd_in = s_rxd[k]; speed_10_100 = s_spd[k];
      @(posedge rx_clk); #1;
      o_en[k] = rx_data_en; o_er[k] = rx_er; o_dv[k] = rx_dv; o_odd[k] = rx_odd_nibble;
      o_chg[k] = status_change; o_data[k] = rx_data;
      o_st[k] = {duplex_status, clock_speed, link_status};
    end
  endtask

  task automatic test_reset();
    n_stim = 0;
    push(1, 0, 0, 8'h00, 0);
    push(1, 1, 1, 8'hFF, 1);
    run_scn();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_data[k], o_en[k], o_dv[k], o_er[k], o_odd[k], o_st[k], o_chg[k]} !== 17'd0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc %0d: got %h exp 0", k,
                 {o_data[k], o_en[k], o_dv[k], o_er[k], o_odd[k], o_st[k], o_chg[k]});
      end
    end
  endtask

  task automatic test_gig();
    logic [7:0] tab[3];
    tab = '{8'h55, 8'hD5, 8'hA1};
    n_stim = 0;
    push(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) push(0, 1, 0, tab[i], 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 8'h00, 0);
    run_scn();
    for (int k = 1; k < n_stim; k++) begin
      n_cmp++;
      if (o_en[k] !== e_en[k] || o_dv[k] !== e_dv[k]) begin
        n_bad++;
        $display("FAIL gig_en_dv cyc %0d: got %b%b exp %b%b", k, o_en[k], o_dv[k], e_en[k], e_dv[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_data[i+1] !== tab[i] || o_en[i+1] !== 1'b1) begin
        n_bad++;
        $display("FAIL gig_byte%0d: got %h en %b exp %h en 1", i, o_data[i+1], o_en[i+1], tab[i]);
      end
    end
  endtask

  task automatic test_nibble();
    logic [3:0] nib[6];
    logic [7:0] tab[3];
    nib = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'hA};
    tab = '{8'h55, 8'hD5, 8'hA1};
    n_stim = 0;
    push(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) push(0, 1, 0, {4'h0, nib[i]}, 1);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 8'h00, 1);
    run_scn();
    for (int k = 1; k < n_stim; k++) begin
      n_cmp++;
      if (o_en[k] !== e_en[k] || o_odd[k] !== e_odd[k]) begin
        n_bad++;
        $display("FAIL nib_en_odd cyc %0d: got %b%b exp %b%b", k, o_en[k], o_odd[k], e_en[k], e_odd[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_data[2*i+2] !== tab[i] || o_en[2*i+2] !== 1'b1 || o_en[2*i+1] !== 1'b0) begin
        n_bad++;
        $display("FAIL nib_byte%0d: got %h exp %h", i, o_data[2*i+2], tab[i]);
      end
    end
  endtask

  task automatic test_odd_end();
    int en_cnt = 0;
    n_stim = 0;
    push(1, 0, 0, 8'h00, 1);
    push(0, 1, 0, 8'h01, 1); push(0, 1, 0, 8'h02, 1); push(0, 1, 0, 8'h03, 1);
    for (int i = 0; i < 4; i++) push(0, 0, 0, 8'h00, 1);
    run_scn();
    for (int k = 0; k < n_stim; k++) en_cnt += int'(o_en[k]);
    n_cmp++;
    if (o_data[2] !== 8'h21 || o_en[2] !== 1'b1 || en_cnt != 1) begin
      n_bad++;
      $display("FAIL odd_byte: got %h en_count %0d exp 21 en_count 1", o_data[2], en_cnt);
    end
    for (int k = 1; k < n_stim; k++) begin
      n_cmp++;
      if (o_odd[k] !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL odd_pulse cyc %0d: got %b exp %b", k, o_odd[k], k == 4);
      end
    end
  endtask

  task automatic test_status();
    int chg_cnt = 0;
    n_stim = 0;
    push(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 8'h0D, 0);
    push(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) push(0, 0, 0, 8'h0D, 0);
    run_scn();
    for (int k = 1; k < n_stim; k++) begin
      chg_cnt += int'(o_chg[k]);
      n_cmp++;
      if (o_st[k] !== e_st[k] || o_chg[k] !== e_chg[k]) begin
        n_bad++;
        $display("FAIL status cyc %0d: got %h/%b exp %h/%b", k, o_st[k], o_chg[k], e_st[k], e_chg[k]);
      end
    end
    n_cmp++;
    if (o_st[7] !== 4'h0 || o_st[8] !== 4'hD || o_chg[8] !== 1'b1 || chg_cnt != 1) begin
      n_bad++;
      $display("FAIL status_commit: got %h->%h chg %0d exp 0->d chg 1", o_st[7], o_st[8], chg_cnt);
    end
  endtask

  task automatic test_mid_switch();
    n_stim = 0;
    push(1, 0, 0, 8'h00, 1);
    push(0, 1, 0, 8'h07, 1); push(0, 1, 0, 8'h03, 1);
    push(0, 1, 0, 8'h08, 0); push(0, 1, 0, 8'h0C, 0);
    push(0, 0, 0, 8'h00, 0); push(0, 0, 0, 8'h00, 0);
    push(0, 1, 1, 8'hE7, 0); push(0, 1, 0, 8'h3B, 0);
    push(0, 0, 0, 8'h00, 0); push(0, 0, 0, 8'h00, 0);
    run_scn();
    for (int k = 1; k < n_stim; k++) begin
      n_cmp++;
      if (o_en[k] !== e_en[k] || o_er[k] !== e_er[k] || (e_en[k] && o_data[k] !== e_data[k])) begin
        n_bad++;
        $display("FAIL mid_switch cyc %0d: got %b%b %h exp %b%b %h", k, o_en[k], o_er[k], o_data[k],
                 e_en[k], e_er[k], e_data[k]);
      end
    end
    n_cmp++;
    if (o_data[4] !== 8'hC8 || o_data[7] !== 8'hE7 || o_er[7] !== 1'b1 || o_data[8] !== 8'h3B) begin
      n_bad++;
      $display("FAIL mid_switch_bytes: got %h %h %h exp c8 e7 3b", o_data[4], o_data[7], o_data[8]);
    end
  endtask

  task automatic test_reset_odd();
    n_stim = 0;
    push(1, 0, 0, 8'h00, 1);
    push(0, 1, 1, 8'h03, 1);
    push(1, 1, 1, 8'h09, 1);
    push(0, 1, 0, 8'h04, 1); push(0, 1, 0, 8'h07, 1);
    push(0, 0, 0, 8'h00, 1); push(0, 0, 0, 8'h00, 1);
    run_scn();
    n_cmp++;
    if ({o_data[2], o_en[2], o_dv[2], o_er[2], o_odd[2], o_st[2], o_chg[2]} !== 17'd0 || o_odd[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_odd: got %h odd_next %b exp 0 odd_next 0",
               {o_data[2], o_en[2], o_dv[2], o_er[2], o_odd[2], o_st[2], o_chg[2]}, o_odd[3]);
    end
    n_cmp++;
    if (o_en[4] !== 1'b1 || o_data[4] !== 8'h74 || o_er[4] !== 1'b0 || o_en[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_then_frame: got en %b data %h er %b exp en 1 data 74 er 0", o_en[4], o_data[4], o_er[4]);
    end
  endtask

  task automatic test_random();
    logic [3:0] idle_tab[4];
    logic [3:0] idle_v;
    logic       spd;
    int         gap, len;
    idle_tab = '{4'hD, 4'h5, 4'h9, 4'h2};
    for (int it = 0; it < 6; it++) begin
      n_stim = 0;
      push(1, 0, 0, 8'h00, 0);
      spd = 1'($urandom_range(0, 1));
      idle_v = 4'h0;
      while (n_stim < 200) begin
        gap = $urandom_range(1, 10);
        idle_v = idle_tab[$urandom_range(0, 3)];
        for (int g = 0; g < gap; g++)
          push(0, 0, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0) ? 8'($urandom) : {4'($urandom), idle_v}, spd);
        if ($urandom_range(0, 2) == 0) spd = ~spd;
        len = $urandom_range(1, 12);
        for (int f = 0; f < len; f++) begin
          if ($urandom_range(0, 9) == 0) spd = ~spd;
          push(($urandom_range(0, 40) == 0), 1, ($urandom_range(0, 9) == 0), 8'($urandom), spd);
        end
      end
      for (int i = 0; i < 3; i++) push(0, 0, 0, {4'h0, idle_v}, spd);
      run_scn();
      for (int k = 0; k < n_stim; k++) begin
        n_cmp++;
        if (o_en[k] !== e_en[k] || o_er[k] !== e_er[k] || o_dv[k] !== e_dv[k] || o_odd[k] !== e_odd[k]) begin
          n_bad++;
          $display("FAIL rand%0d_ctl cyc %0d: got en%b er%b dv%b odd%b exp en%b er%b dv%b odd%b", it, k,
                   o_en[k], o_er[k], o_dv[k], o_odd[k], e_en[k], e_er[k], e_dv[k], e_odd[k]);
        end
        n_cmp++;
        if ((e_en[k] && o_data[k] !== e_data[k]) || o_st[k] !== e_st[k] || o_chg[k] !== e_chg[k]) begin
          n_bad++;
          $display("FAIL rand%0d_data cyc %0d: got %h st %h chg %b exp %h st %h chg %b", it, k,
                   o_data[k], o_st[k], o_chg[k], e_data[k], e_st[k], e_chg[k]);
        end
      end
    end
  endtask

  initial begin
    rx_reset = 1'b1; speed_10_100 = 1'b0; gmii_rx_dv_in = 1'b0;
    gmii_rx_er_in = 1'b0; gmii_rxd_in = 8'h00;
    test_reset();
    test_gig();
    test_nibble();
    test_odd_end();
    test_status();
    test_mid_switch();
    test_reset_odd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_adapter.md
RGMII_RX_ADAPTER -- requirements
Module: rgmii_rx_adapter

Interface
REQ-001 Parameter STATUS_FILTER, default 4, meaning: consecutive identical in-band samples required to commit status; legal range 1..15.
REQ-002 Parameter AUTO_SPEED, default 1, meaning: 1 = mode from committed clock_speed; 0 = mode from speed_10_100 input.
REQ-003 Clocking SHALL be one clock with a synchronous, active-high reset.
REQ-004 rx_clk  in  1  receive clock from the RGMII input stage (125/25/2.5 MHz); the only clock.
REQ-005 rx_reset  in  1  synchronous active-high reset.
REQ-006 speed_10_100  in  1  external mode select; used only when AUTO_SPEED=0.
REQ-007 gmii_rxd_in  in  8  IDDR-decoded data; 10/100 nibble valid in [3:0].
REQ-008 gmii_rx_dv_in  in  1  decoded data valid.
REQ-009 gmii_rx_er_in  in  1  decoded receive error.
REQ-010 rx_data  out  8  assembled byte.
REQ-011 rx_data_en  out  1  one-cycle byte strobe; qualifies rx_data and rx_er.
REQ-012 rx_dv  out  1  frame active; gmii_rx_dv_in delayed by 1 cycle.
REQ-013 rx_er  out  1  error for the byte on rx_data.
REQ-014 rx_odd_nibble  out  1  one-cycle pulse when a 10/100 frame ends on a half byte.
REQ-015 link_status, clock_speed[1:0], duplex_status  out  1/2/1  committed in-band status.
REQ-016 status_change  out  1  one-cycle pulse when any committed status bit changes.

Function
REQ-017 Mode: mode_10_100 = AUTO_SPEED ? (clock_speed != 2'b10) : speed_10_100.
REQ-018 Mode SHALL be latched on the cycle gmii_rx_dv_in rises; changes mid-frame are ignored until the next rising edge.
REQ-019 1G mode: registered pass-through, 1-cycle latency; rx_data<=gmii_rxd_in, rx_data_en<=gmii_rx_dv_in, rx_er<=gmii_rx_er_in & gmii_rx_dv_in.
REQ-020 10/100 FSM states: IDLE, EVEN (expecting low nibble), ODD (low nibble held).
REQ-021 Transitions: IDLE+dv -> ODD, holding the nibble; ODD+dv -> EVEN, emitting a byte; EVEN+dv -> ODD, holding the nibble; EVEN+!dv -> IDLE; ODD+!dv -> IDLE, discarding the held nibble.
REQ-022 Emitted byte = {current [3:0], held nibble}; rx_data_en high for exactly that cycle, 1 cycle after the high nibble is sampled.
REQ-023 In 10/100 mode, rx_er = OR of gmii_rx_er_in over both nibbles of the byte.
REQ-024 ODD+!dv SHALL pulse rx_odd_nibble for 1 cycle, with no rx_data_en.
REQ-025 gmii_rx_er_in with dv=0 (carrier extension/false carrier) SHALL NOT assert rx_er or rx_data_en.
REQ-026 In-band sample valid only when gmii_rx_dv_in=0 and gmii_rx_er_in=0; candidate = gmii_rxd_in[3:0] = {duplex, speed[1:0], link}.
REQ-027 Filter counter: reset to 1 when the candidate differs from the previous candidate, otherwise increment (saturating at 15); the counter freezes on non-sample cycles.
REQ-028 On the edge where the count reaches STATUS_FILTER and the candidate differs from the committed value, commit it and pulse status_change for 1 cycle.
REQ-029 STATUS_FILTER=1 SHALL give an unfiltered update on every idle cycle.

Reset
REQ-030 rx_reset SHALL force all outputs to 0, FSM to IDLE, latched mode to 0, filter counter and previous candidate to 0.
REQ-031 Reset in ODD SHALL drop the held nibble with no rx_odd_nibble pulse; outputs are 0 on the cycle after reset is sampled.
REQ-032 Reset SHALL take priority over all simultaneous events.

Structure
REQ-033 A shared rgmii_defs package SHALL hold FSM state encodings and speed constants SPEED_2M5=2'b00, SPEED_25M=2'b01, SPEED_125M=2'b10.
REQ-034 The status filter SHALL be a sub-module rgmii_status_filter (parameter STATUS_FILTER); the nibble assembler stays in the top.

Verification
REQ-035 Scenario: AUTO_SPEED=0, speed_10_100=0, dv=1 with bytes 0x55,0xD5,0xA1 -> same bytes on rx_data one cycle later, rx_data_en high 3 consecutive cycles.
REQ-036 Scenario: speed_10_100=1, nibbles 5,5,5,D,1,A -> bytes 0x55,0xD5,0xA1, with rx_data_en on alternate cycles.
REQ-037 Scenario: 10/100, nibbles 1,2,3 then dv=0 -> one byte 0x21, rx_odd_nibble pulse 1 cycle after dv falls, no second rx_data_en.
REQ-038 Scenario: STATUS_FILTER=4, idle rxd=0xD for 3 cycles then 0x0 -> no change; 0xD for 4 cycles -> link=1, clock_speed=2'b10, duplex=1, status_change pulses once.
REQ-039 Scenario: AUTO_SPEED=0, speed_10_100 toggled 1->0 mid-frame -> nibble assembly continues to frame end; the next frame runs in 1G mode.
REQ-040 Scenario: rx_reset asserted in ODD with er=1 -> all outputs 0 next cycle, no rx_odd_nibble pulse, FSM in IDLE.
